register_file_wb_arbiter: RTL

//  Shares the single register_file write port between two writeback requesters:
//  req0 = ALU result, req1 = load/memory result.
//  - Arbitrates between them, registers the winning write into an output stage,
//    and drives wr_en/wr_reg/wr_data of register_file one cycle after acceptance.
//  - Exposes two forwarding lookups so read ports see the staged write before it

---
 rtl/register_file_wb_arbiter_if.sv | 44 ++++
 rtl/register_file_wb_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/register_file_wb_arbiter_if.sv
// Writeback bus between the two requesters, the register-file write port and the
// read-port forwarding lookups. slave = arbiter side, master = everything else.
interface register_file_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] fwd_reg_1;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic [ADDR_W-1:0] fwd_reg_2;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    output wr_en, wr_reg, wr_data,
    input  fwd_reg_1, fwd_reg_2,
    output fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2
  );

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    input  wr_en, wr_reg, wr_data,
    output fwd_reg_1, fwd_reg_2,
    input  fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2
  );
endinterface

// File: rtl/register_file_wb_arbiter.sv
// Arbitrates ALU (req0) and load (req1) writebacks onto the register-file write port
// through one registered stage, with two forwarding lookups on the staged write.
// Build option WB_ARB_ROUND_ROBIN_EN: round-robin; otherwise fixed priority to req0
// with a starvation guard for req1.
module register_file_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  register_file_wb_arbiter_if.slave bus
);

  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_data;

  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] wr_reg_d, wr_reg_q;
  logic [DATA_W-1:0] wr_data_d, wr_data_q;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic              rr_ptr_d, rr_ptr_q;  // 0: req0 wins the next contested cycle
`else
  logic [3:0]        starve_d, starve_q;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt0     = ~rr_ptr_q;
      gnt1     = rr_ptr_q;
      rr_ptr_d = ~rr_ptr_q;
    end else begin
      gnt0 = bus.req0_valid;
      gnt1 = bus.req1_valid;
    end
`else
    starve_d = starve_q;
    if (bus.req1_valid && (!bus.req0_valid || (starve_q == 4'(STARVE_LIMIT)))) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = bus.req0_valid;
    end
    if (!bus.req1_valid || gnt1) begin
      starve_d = '0;
    end else if (starve_q != '1) begin
      starve_d = starve_q + 4'd1;
    end
`endif
    acc_reg  = gnt1 ? bus.req1_reg  : bus.req0_reg;
    acc_data = gnt1 ? bus.req1_data : bus.req0_data;

    // x0 writes are accepted but never staged; reg/data hold while idle.
    wr_en_d   = (gnt0 || gnt1) && (acc_reg != '0);
    wr_reg_d  = wr_en_d ? acc_reg  : wr_reg_q;
    wr_data_d = wr_en_d ? acc_data : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      rr_ptr_q  <= 1'b0;
`else
      starve_q  <= '0;
`endif
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
      rr_ptr_q  <= rr_ptr_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_reg     = wr_reg_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.fwd_hit_1  = wr_en_q && (bus.fwd_reg_1 == wr_reg_q) && (wr_reg_q != '0);
  assign bus.fwd_data_1 = wr_data_q;
  assign bus.fwd_hit_2  = wr_en_q && (bus.fwd_reg_2 == wr_reg_q) && (wr_reg_q != '0);
  assign bus.fwd_data_2 = wr_data_q;

endmodule
